program_sequencer: RTL and testbench

- Controller that loads a program into a local instruction store and sequences the 8-bit microprocessor from it.
- Accepts bytes over a valid/ready load port, serves instruction = mem[pc] back to the processor, and holds the processor in reset while loading.
- Gates processor execution with one-cycle enable pulses in run, single-step or halted modes.
- Sits between the board-level control inputs and the Microprocessor instruction/pc interface.

---
 rtl/program_sequencer.sv | 150 +++++++++++++++
 tb/tb_program_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program loader and run/step/halt sequencer for the 8-bit CPU.
// Ports: load_*, run/step/halt_req, pc in; instruction, cpu_en, cpu_rst, halted, state, load_count out (BREAKPOINT_EN adds bp_addr, bp_valid, bp_hit).
module program_sequencer #(
  parameter int MEM_DEPTH = 32,
  parameter int PC_W = 5,
  parameter int RUN_DIV = 4,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input  logic          origclk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          run_req,
  input  logic          step_req,
  input  logic          halt_req,
  input  logic [7:0]    pc,
`ifdef BREAKPOINT_EN
  input  logic [7:0]    bp_addr,
  input  logic          bp_valid,
  output logic          bp_hit,
`endif
  output logic [7:0]    instruction,
  output logic          cpu_en,
  output logic          cpu_rst,
  output logic          halted,
  output logic [2:0]    state,
  output logic [PC_W:0] load_count
);

  localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [PC_W:0] CNT_ONE = (PC_W+1)'(1);
  localparam logic [PC_W:0] CNT_LAST = (PC_W+1)'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CPURST = 3'd2,
    S_PAUSE  = 3'd3,
    S_RUN    = 3'd4,
    S_HALT   = 3'd5
  } seq_state_e;

  seq_state_e       cur, nxt;
  logic [7:0]       mem [MEM_DEPTH];
  logic [DIV_W-1:0] div;
  logic             accept, due, is_halt, bp, en_d, bp_d;
  logic [PC_W-1:0]  wr_addr;

  assign state   = cur;
  assign accept  = load_valid & load_ready;
  assign due     = (cur == S_RUN) && (div == DIV_LAST);
  assign is_halt = (instruction == HALT_OP);
  assign wr_addr = (cur == S_LOAD) ? load_count[PC_W-1:0] : '0;

`ifdef BREAKPOINT_EN
  assign bp = bp_valid && (pc == bp_addr);
`else
  assign bp = 1'b0;
`endif

  always_comb begin
    nxt  = cur;
    en_d = 1'b0;
    bp_d = 1'b0;
    unique case (cur)
      S_IDLE, S_HALT: begin
        if (accept) nxt = load_last ? S_CPURST : S_LOAD;
      end
      S_LOAD: begin
        if (accept && (load_last || load_count == CNT_LAST))
          nxt = S_CPURST;
      end
      S_CPURST: begin
        if (div == DIV_ONE) nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (halt_req) nxt = S_HALT;
        else if (accept) nxt = load_last ? S_CPURST : S_LOAD;
        else if (run_req) nxt = S_RUN;
        else if (step_req && !cpu_en) begin
          if (is_halt) nxt = S_HALT;
          else en_d = 1'b1;
        end
      end
      S_RUN: begin
        if (halt_req) nxt = S_HALT;
        else if (!run_req) nxt = S_PAUSE;
        else if (due) begin
          if (bp) begin
            nxt  = S_PAUSE;
            bp_d = 1'b1;
          end else if (is_halt) nxt = S_HALT;
          else en_d = !cpu_en;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Instruction store is not reset; contents survive reset.
  always_ff @(posedge origclk) begin
    if (accept) mem[wr_addr] <= load_data;
  end

  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      cur         <= S_IDLE;
      div         <= '0;
      load_count  <= '0;
      instruction <= 8'h00;
      cpu_en      <= 1'b0;
      cpu_rst     <= 1'b1;
      load_ready  <= 1'b0;
      halted      <= 1'b0;
`ifdef BREAKPOINT_EN
      bp_hit      <= 1'b0;
`endif
    end else begin
      cur    <= nxt;
      cpu_en <= en_d;
`ifdef BREAKPOINT_EN
      bp_hit <= bp_d;
`endif
      if (32'(pc) < 32'(load_count))
        instruction <= mem[pc[PC_W-1:0]];
      else
        instruction <= 8'h00;
      // A byte outside LOAD restarts the program at address 0.
      if (accept)
        load_count <= (cur == S_LOAD) ? load_count + CNT_ONE : CNT_ONE;
      // div times CPURST length and the RUN pulse period.
      if (nxt != cur) div <= '0;
      else if (cur == S_CPURST) div <= div + DIV_ONE;
      else if (cur == S_RUN) div <= due ? '0 : div + DIV_ONE;
      load_ready <= (nxt == S_IDLE) || (nxt == S_LOAD) ||
                    (nxt == S_PAUSE) || (nxt == S_HALT);
      cpu_rst    <= (nxt == S_IDLE) || (nxt == S_LOAD) ||
                    (nxt == S_CPURST);
      halted     <= (nxt == S_HALT);
    end
  end

  logic unused_bp;
  assign unused_bp = bp_d;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer.
// Drives on negedge, samples on negedge after each rising edge.
module tb_program_sequencer;

  logic       origclk = 1'b0;
  logic       reset;
  logic       load_valid, load_last, load_ready;
  logic [7:0] load_data;
  logic       run_req, step_req, halt_req;
  logic [7:0] pc, instruction;
  logic       cpu_en, cpu_rst, halted;
  logic [2:0] state;
  logic [5:0] load_count;
`ifdef BREAKPOINT_EN
  logic [7:0] bp_addr = 8'h00;
  logic       bp_valid = 1'b0;
  logic       bp_hit;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 origclk = ~origclk;

  program_sequencer dut (
    .origclk(origclk),
    .reset(reset),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .run_req(run_req),
    .step_req(step_req),
    .halt_req(halt_req),
    .pc(pc),
`ifdef BREAKPOINT_EN
    .bp_addr(bp_addr),
    .bp_valid(bp_valid),
    .bp_hit(bp_hit),
`endif
    .instruction(instruction),
    .cpu_en(cpu_en),
    .cpu_rst(cpu_rst),
    .halted(halted),
    .state(state),
    .load_count(load_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge origclk);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    cyc(1);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    load_valid = 0; load_last = 0; load_data = 0;
    run_req = 0; step_req = 0; halt_req = 0; pc = 0;
    #1 reset = 1'b0;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ready", load_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", load_count, 0);
    chk("rst_en", cpu_en, 0);
    chk("rst_instr", instruction, 0);
    reset = 1'b1;
    cyc(1);
    chk("idle_ready", load_ready, 1);

    // 5-byte program
    send(8'h44, 0);
    chk("load_state", state, 1);
    send(8'h49, 0);
    send(8'h19, 0);
    send(8'h84, 0);
    send(8'hC3, 1);
    chk("ld5_cnt", load_count, 5);
    chk("crst_1", state, 2);
    chk("crst_rst", cpu_rst, 1);
    cyc(1);
    chk("crst_2", state, 2);
    cyc(1);
    chk("pause", state, 3);
    chk("pause_rst", cpu_rst, 0);
    pc = 8'd2;
    cyc(1);
    chk("instr_pc2", instruction, 8'h19);
    pc = 8'd7;
    cyc(1);
    chk("instr_pc7", instruction, 8'h00);
    pc = 8'd0;
    cyc(1);
    chk("instr_pc0", instruction, 8'h44);

    // single step
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    chk("step_en", cpu_en, 1);
    chk("step_state", state, 3);
    cyc(1);
    chk("step_en_off", cpu_en, 0);

    // free run, pulses every 4 cycles
    run_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk($sformatf("run_en_%0d", k), cpu_en, (k == 5 || k == 9));
    end
    run_req = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      pulses += int'(cpu_en);
    end
    chk("stop_pulses", pulses, 0);
    chk("stop_state", state, 3);

    // run beats step, halt beats run
    step_req = 1'b1;
    run_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    chk("runstep_state", state, 4);
    chk("runstep_en", cpu_en, 0);
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    chk("halt_state", state, 5);
    chk("halt_flag", halted, 1);
    chk("halt_en", cpu_en, 0);
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    run_req = 1'b0;
    chk("halt_step_en", cpu_en, 0);
    chk("halt_stay", state, 5);
    chk("halt_ready", load_ready, 1);

    // program with HALT_OP at byte 3
    send(8'h01, 0);
    chk("reload_state", state, 1);
    chk("reload_cnt", load_count, 1);
    send(8'h02, 0);
    send(8'h03, 0);
    send(8'hFF, 0);
    send(8'h05, 1);
    cyc(2);
    chk("p6_pause", state, 3);
    pc = 8'd3;
    cyc(1);
    chk("p6_instr", instruction, 8'hFF);
    run_req = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      pulses += int'(cpu_en);
    end
    run_req = 1'b0;
    chk("hop_pulses", pulses, 0);
    chk("hop_state", state, 5);
    chk("hop_halted", halted, 1);
    send(8'h77, 0);
    chk("hop_reload_cnt", load_count, 1);
    chk("hop_reload_st", state, 1);

    // overflow: 33 bytes, no last
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    for (int i = 0; i < 33; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i + 16);
      cyc(1);
      if (i == 30) chk("ovf_ready_30", load_ready, 1);
      if (i == 31) chk("ovf_ready_31", load_ready, 0);
    end
    load_valid = 1'b0;
    chk("ovf_cnt", load_count, 32);
    chk("ovf_state", state, 2);
    cyc(1);
    chk("ovf_pause", state, 3);
    pc = 8'd0;
    cyc(1);
    chk("ovf_addr0", instruction, 8'h10);
    pc = 8'd31;
    cyc(1);
    chk("ovf_addr31", instruction, 8'h2F);
    pc = 8'd0;

    // async reset mid-run
    run_req = 1'b1;
    cyc(3);
    chk("pre_rst_run", state, 4);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_en", cpu_en, 0);
    chk("arst_cnt", load_count, 0);
    run_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
